// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state encoding, opcode/funct constants, control-field encodings
// and the control-word struct shared by the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_INT       = 4'd12,
        S_HALT      = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_VECTOR = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       epc_write;
        logic       cause_write;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       cause;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    // R-type is legal only for add/sub/and/or/slt; other opcodes only for the supported set.
    function automatic logic op_illegal(input logic [5:0] op, input logic [5:0] fn);
        return op == OP_RTYPE ? !(fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})
                              : !(op inside {OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: combinational mapping from FSM state to datapath control word.
//   state_i   current FSM state
//   last_i    final cycle of a held memory access (gates ir_write/pc_write in FETCH)
//   illegal_i decoded opcode/funct is illegal (meaningful in DECODE only)
//   cause_i   latched interrupt cause, presented in INT
//   ctrl_o    control word
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   last_i,
    input  logic   illegal_i,
    input  logic   cause_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_ONE;
                ctrl_o.ir_write  = last_i;
                ctrl_o.pc_write  = last_i;
                ctrl_o.pc_source = PC_ALU;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.illegal   = illegal_i;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_ADDI_WB: ctrl_o.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PC_JUMP;
            end
            S_INT: begin
                ctrl_o.epc_write   = 1'b1;
                ctrl_o.cause_write = 1'b1;
                ctrl_o.pc_write    = 1'b1;
                ctrl_o.pc_source   = PC_VECTOR;
                ctrl_o.cause       = cause_i;
            end
            S_HALT: ctrl_o.halted = 1'b1;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore multi-cycle MIPS control FSM with memory wait states,
// interrupt entry at instruction boundaries, illegal-opcode trap and single-step halt.
//   clock_i/reset_i      clock, synchronous active-high reset
//   opcode_i/funct_i     instruction register fields
//   zero_i               ALU zero flag (consumed by the datapath with pc_write_cond)
//   interrupt_i          level interrupt request
//   step_mode_i/step_i   halt-after-instruction mode and step request
//   *_o strobes/selects  datapath controls; state_o, halted_o, illegal_o status
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int INT_EN      = 1,
    parameter int STEP_EN     = 1
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       interrupt_i,
    input  logic       step_mode_i,
    input  logic       step_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic       epc_write_o,
    output logic       cause_write_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       cause_o,
    output logic [3:0] state_o,
    output logic       halted_o,
    output logic       illegal_o
);

    state_e     state_q, state_d, bnd_state;
    logic [3:0] wait_q, wait_d;
    logic       int_pend_q, int_pend_d;
    logic       step_q;
    logic       cause_q, cause_d;
    logic       last, illegal_op, step_edge;
    ctrl_t      ctrl, ctrl_out;
    logic       unused_zero;

    assign unused_zero = zero_i;
    assign last        = wait_q == 4'(WAIT_STATES);
    assign illegal_op  = op_illegal(opcode_i, funct_i);
    assign step_edge   = STEP_EN != 0 && step_i && !step_q;
    assign bnd_state   = INT_EN != 0 && int_pend_q ? S_INT :
                         STEP_EN != 0 && step_mode_i ? S_HALT : S_FETCH;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = last ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = illegal_op ? (INT_EN != 0 ? S_INT : S_FETCH) :
                                   opcode_i == OP_LW || opcode_i == OP_SW ? S_MEM_ADDR :
                                   opcode_i == OP_RTYPE ? S_EXECUTE :
                                   opcode_i == OP_BEQ ? S_BRANCH :
                                   opcode_i == OP_J ? S_JUMP : S_ADDI_EX;
            S_MEM_ADDR:  state_d = opcode_i == OP_SW ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = last ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = last ? bnd_state : S_MEM_WRITE;
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = bnd_state;
            S_EXECUTE:   state_d = S_R_WB;
            S_ADDI_EX:   state_d = S_ADDI_WB;
            S_INT:       state_d = S_FETCH;
            S_HALT:      state_d = !step_edge ? S_HALT :
                                   INT_EN != 0 && int_pend_q ? S_INT : S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // INT is only ever entered from DECODE on an illegal opcode; every other entry is external.
    assign cause_d    = state_d == S_INT ? state_q == S_DECODE : cause_q;
    assign wait_d     = state_d == state_q ? wait_q + 4'd1 : 4'd0;
    assign int_pend_d = (INT_EN != 0 && interrupt_i) || (int_pend_q && state_d != S_INT);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_FETCH;
            wait_q     <= 4'd0;
            int_pend_q <= 1'b0;
            step_q     <= 1'b0;
            cause_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            int_pend_q <= int_pend_d;
            step_q     <= step_i;
            cause_q    <= cause_d;
        end
    end

    mips_ctrl_decode u_decode (
        .state_i   (state_q),
        .last_i    (last),
        .illegal_i (illegal_op),
        .cause_i   (cause_q),
        .ctrl_o    (ctrl)
    );

    // Reset silences the datapath immediately so an aborted access writes nothing.
    assign ctrl_out        = reset_i ? '0 : ctrl;
    assign pc_write_o      = ctrl_out.pc_write;
    assign pc_write_cond_o = ctrl_out.pc_write_cond;
    assign i_or_d_o        = ctrl_out.i_or_d;
    assign mem_read_o      = ctrl_out.mem_read;
    assign mem_write_o     = ctrl_out.mem_write;
    assign ir_write_o      = ctrl_out.ir_write;
    assign mem_to_reg_o    = ctrl_out.mem_to_reg;
    assign reg_dst_o       = ctrl_out.reg_dst;
    assign reg_write_o     = ctrl_out.reg_write;
    assign alu_src_a_o     = ctrl_out.alu_src_a;
    assign epc_write_o     = ctrl_out.epc_write;
    assign cause_write_o   = ctrl_out.cause_write;
    assign alu_src_b_o     = ctrl_out.alu_src_b;
    assign alu_op_o        = ctrl_out.alu_op;
    assign pc_source_o     = ctrl_out.pc_source;
    assign cause_o         = ctrl_out.cause;
    assign halted_o        = ctrl_out.halted;
    assign illegal_o       = ctrl_out.illegal;
    assign state_o         = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle control unit for the next-generation MIPS core. It replaces single-cycle combinational control with a Moore FSM that sequences fetch, decode, execute, memory and write-back over several clocks. It adds a configurable memory wait-state count, interrupt entry at instruction boundaries, illegal-opcode trapping and a single-step debug mode. It sits between the instruction register/ALU zero flag and the shared multi-cycle datapath. The datapath is word-addressed, so PC increments by 1.

Parameters:
WAIT_STATES, 0, extra cycles each memory access (FETCH, MEM_READ, MEM_WRITE) is held; 0..15
INT_EN, 1, 1 enables interrupt entry; 0 leaves the interrupt pin ignored
STEP_EN, 1, 1 enables the step_mode/step debug path; 0 ties halting off

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]; used only for illegal R-type detection
zero  in  1  ALU zero flag
interrupt  in  1  external interrupt request, level
step_mode  in  1  1 = halt after every instruction
step  in  1  debug step request; rising edge detected internally
pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, epc_write, cause_write  out  1 each  datapath strobes and selects
alu_src_b  out  2  00 regB, 01 constant 1, 10 sign-extended imm, 11 reserved (drive 00)
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 interrupt vector
cause  out  1  0 = external interrupt, 1 = illegal opcode; valid with cause_write
state  out  4  current state encoding, for display
halted  out  1  high while in HALT
illegal  out  1  one-cycle pulse on illegal-opcode detection

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, INT 12, HALT 13. Encodings 14 and 15 are illegal; from either, go to FETCH next cycle with all strobes 0.
- Reset: reset=1 at an edge loads state=FETCH, wait counter=0, int_pending=0, step edge register=0. While reset=1, all strobes, selects, halted and illegal are forced to 0 combinationally.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. Any other opcode is illegal. An R-type with funct outside {add, sub, and, or, slt} is also illegal.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00. The state holds for WAIT_STATES+1 cycles. ir_write=1 and pc_write=1 (pc_source=00) only in the final cycle, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - lw/sw → MEM_ADDR
  - R-type → EXECUTE
  - beq → BRANCH
  - j → JUMP
  - addi → ADDI_EX
  - illegal → INT with cause=1 and an illegal pulse this cycle (suppressed when INT_EN=0; then go to FETCH instead).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; then → MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, i_or_d=1, held WAIT_STATES+1 cycles, then → MEM_WB.
- MEM_WRITE: mem_write=1, i_or_d=1, held WAIT_STATES+1 cycles.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. The PC updates only if zero=1; the datapath ANDs pc_write_cond with zero.
- JUMP: pc_write=1, pc_source=10.
- Instruction boundary: the state after MEM_WB, MEM_WRITE (final cycle), R_WB, ADDI_WB, BRANCH and JUMP. Priority at the boundary:
  1. int_pending (INT_EN=1) → INT
  2. else step_mode (STEP_EN=1) → HALT
  3. else → FETCH
- int_pending: set on any cycle where interrupt=1 (INT_EN=1). Cleared on entry to INT. If interrupt=1 on the same cycle INT is entered, int_pending stays set.
- INT: lasts exactly one cycle, asserting epc_write=1, cause_write=1, pc_write=1, pc_source=11. cause is 0 for an external interrupt and 1 for an illegal opcode. Then → FETCH unconditionally; a nested pending interrupt is taken at the next boundary.
- HALT: halted=1, all strobes 0. A detected step rising edge → INT if int_pending, else FETCH. A step edge outside HALT is ignored. If step_mode drops while in HALT, still wait for a step edge.
- Wait counter: 4-bit; cleared on every state change. Reset mid-access aborts the access cleanly, with no partial ir_write or pc_write.

Decomposition:
- Package mips_ctrl_pkg: state encoding constants, opcode/funct constants, alu_op/alu_src_b/pc_source encodings.
- Sub-module mips_ctrl_decode: combinational state→control-word mapping. The top holds the FSM, wait counter, int_pending and step edge detection.

Test Plan:
- WAIT_STATES=0; program lw, sw, add, addi, beq, j. Check states: lw 0→1→2→3→4 (5 cycles), sw 0→1→2→5 (4), add 0→1→6→7 (4), beq with zero=1 shows pc_write_cond=1 and pc_source=01 in state 8, j shows pc_write=1 and pc_source=10 in state 9.
- WAIT_STATES=2; lw → FETCH and MEM_READ each last 3 cycles, ir_write high only in FETCH's third cycle, 9 cycles total.
- Pulse interrupt one cycle during EXECUTE → INT follows R_WB, epc_write=cause_write=1, cause=0, pc_source=11, then FETCH.
- opcode=111111 in DECODE → illegal pulses one cycle, next state INT with cause=1; with INT_EN=0, next state is FETCH.
- step_mode=1 → after add, state=13 and halted=1 indefinitely; step pulse → FETCH; a second step pulse while not halted has no effect.
- Assert reset during MEM_READ (WAIT_STATES=3) → all strobes 0 that cycle, state=FETCH after the edge, int_pending cleared.
